// File: rtl/mips_mem_responder_if.sv
// Memory request/response bundle between the multicycle MIPS control FSM
// (master) and the memory responder (slave).
//
// Handshake: the master holds req high, with we/addr/wdata, across a clock
// edge to start an access. The slave accepts it on that edge only when it
// is idle or in its response cycle. From then on it ignores req/we/addr/wdata
// until it drives ready high for exactly one cycle. On that cycle rdata (for
// reads) and misaligned are valid, and they hold until the next response.
// busy is high while an accepted access is in flight.
//
// Signals: req, we, addr[N-1:0], wdata[N-1:0]      (master -> slave)
//          rdata[N-1:0], ready, busy, misaligned  (slave -> master)
interface mips_mem_responder_if #(
  parameter int N = 32
);
  logic         req;
  logic         we;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         ready;
  logic         busy;
  logic         misaligned;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, misaligned
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, misaligned
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified instruction/data word memory for the multicycle MIPS core. It
// services one access at a time and adds a fixed access latency.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous, active-high reset (aborts an in-flight access)
//   bus       - slave side of mips_mem_responder_if (req/we/addr/wdata in,
//               rdata/ready/busy/misaligned out)
//   dbg_state - current FSM state (0 = IDLE, 1 = WAIT, 2 = RESP)
//
// A request sampled at edge e0 commits at edge e(LATENCY). ready is high in
// the cycle after that edge. Word index = addr[ADDR_W+1:2], so higher address
// bits alias. A byte address with addr[1:0] != 0 suppresses the access and
// reports misaligned with the response.
module mips_mem_responder #(
  parameter int N       = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_idx;
  logic [1:0]          lat_off;
  logic [N-1:0]        lat_wdata;
  logic [N-1:0]        rdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                mis_q;
  logic                commit;
  logic                aligned;

  logic [N-1:0] mem [2**ADDR_W];

  // Upper address bits only alias; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.addr[N-1:ADDR_W+2]};

  assign commit  = (state == WAIT) && (cnt == 4'd0);
  assign aligned = (lat_off == 2'b00);

  // Memory has no reset. The write fires only on the commit edge. An async
  // reset forces state to IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (commit && aligned && lat_we) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_off   <= 2'b00;
      lat_wdata <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.req) begin
            state     <= WAIT;
            busy_q    <= 1'b1;
            cnt       <= CNT_LOAD;
            lat_we    <= bus.we;
            lat_idx   <= bus.addr[ADDR_W+1:2];
            lat_off   <= bus.addr[1:0];
            lat_wdata <= bus.wdata;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= RESP;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            if (!aligned) begin
              mis_q <= 1'b1;
            end else begin
              mis_q <= 1'b0;
              if (!lat_we) begin
                rdata_q <= mem[lat_idx];
              end
            end
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          // A request presented during the response cycle starts immediately.
          if (bus.req) begin
            state     <= WAIT;
            busy_q    <= 1'b1;
            cnt       <= CNT_LOAD;
            lat_we    <= bus.we;
            lat_idx   <= bus.addr[ADDR_W+1:2];
            lat_off   <= bus.addr[1:0];
            lat_wdata <= bus.wdata;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.misaligned = mis_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;
  localparam int N       = 32;
  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 2**ADDR_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mips_mem_responder_if #(.N(N)) bus ();

  mips_mem_responder #(
    .N(N), .ADDR_W(ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0] ref_mem [int];      // word index -> last written data
  logic [N-1:0] m_rdata;            // model view after all issued accesses
  bit           m_mis;
  bit           m_known;
  logic [N-1:0] cur_rdata;          // model view of what the DUT shows now
  bit           cur_mis;
  bit           cur_known;

  logic [N-1:0] exp_q[$];
  bit           mis_q[$];
  bit           known_q[$];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outcome of one access from the rules: word index wraps modulo DEPTH,
  // misaligned accesses touch nothing, writes leave rdata alone.
  task automatic model_access(input bit w, input logic [N-1:0] a, input logic [N-1:0] d);
    int idx;
    idx = int'((a / 4) % DEPTH);
    if ((a % 4) != 0) begin
      m_mis = 1'b1;
    end else if (w) begin
      ref_mem[idx] = d;
      m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (ref_mem.exists(idx)) begin
        m_rdata = ref_mem[idx];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
    exp_q.push_back(m_rdata);
    mis_q.push_back(m_mis);
    known_q.push_back(m_known);
  endtask

  task automatic model_reset();
    m_rdata   = '0; m_mis   = 1'b0; m_known   = 1'b1;
    cur_rdata = '0; cur_mis = 1'b0; cur_known = 1'b1;
    exp_q.delete(); mis_q.delete(); known_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit w, input logic [N-1:0] a, input logic [N-1:0] d);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    model_access(w, a, d);
  endtask

  // Wait through the accepting edge and the latency, checking the response.
  task automatic finish_req(input string tag);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    // Garbage on the inputs while in flight must be ignored.
    bus.req   = 1'($urandom_range(0, 1));
    bus.we    = 1'($urandom_range(0, 1));
    bus.addr  = $urandom();
    bus.wdata = $urandom();
    check({tag, "_busy_accept"}, N'(bus.busy), N'(1));
    check({tag, "_ready_accept"}, N'(bus.ready), N'(0));
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == LATENCY) bus.req = 1'b0;
      if (bus.ready === 1'b1) begin
        check({tag, "_latency"}, N'(i), N'(LATENCY));
        got = 1'b1;
        break;
      end
      check({tag, "_busy_wait"}, N'(bus.busy), N'(1));
    end
    bus.req = 1'b0;
    if (!got) begin
      check({tag, "_ready_timeout"}, N'(bus.ready), N'(1));
    end else begin
      cur_rdata = exp_q.pop_front();
      cur_mis   = mis_q.pop_front();
      cur_known = known_q.pop_front();
      check({tag, "_busy_resp"}, N'(bus.busy), N'(0));
      check({tag, "_misaligned"}, N'(bus.misaligned), N'(cur_mis));
      if (cur_known) check({tag, "_rdata"}, bus.rdata, cur_rdata);
    end
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_ready", N'(bus.ready), N'(0));
      check("idle_busy", N'(bus.busy), N'(0));
      check("idle_misaligned", N'(bus.misaligned), N'(cur_mis));
      if (cur_known) check("idle_rdata", bus.rdata, cur_rdata);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rdata"}, bus.rdata, '0);
    check({tag, "_ready"}, N'(bus.ready), N'(0));
    check({tag, "_busy"}, N'(bus.busy), N'(0));
    check({tag, "_misaligned"}, N'(bus.misaligned), N'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [N-1:0] a;
    bit           w;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_held");
    @(negedge clk); rst = 1'b0;
    #1;
    idle(3);

    // Write 0x10, then a back-to-back read of the same word from RESP.
    start_req(1'b1, 32'h10, 32'hDEADBEEF);
    finish_req("wr10");
    check("wr10_rdata_zero", bus.rdata, 32'h0);
    start_req(1'b0, 32'h10, 32'h0);
    finish_req("rd10_b2b");
    check("rd10_value", bus.rdata, 32'hDEADBEEF);
    idle(1);

    // Misaligned read keeps the previous rdata.
    start_req(1'b0, 32'h412, 32'h0);
    finish_req("rd412_mis");
    check("rd412_flag", N'(bus.misaligned), N'(1));
    check("rd412_hold", bus.rdata, 32'hDEADBEEF);
    idle(2);

    // Aliasing: 0x404 and 0x004 are the same word.
    start_req(1'b1, 32'h404, 32'h12345678);
    finish_req("wr404");
    start_req(1'b0, 32'h004, 32'h0);
    finish_req("rd004_alias");
    check("rd004_value", bus.rdata, 32'h12345678);

    // Known content at 0x20, then an aborted write to it.
    start_req(1'b1, 32'h20, 32'h11111111);
    finish_req("wr20_pre");
    idle(1);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("abort_busy", N'(bus.busy), N'(1));
    rst = 1'b1;
    #1;
    check_cleared("abort_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    start_req(1'b0, 32'h20, 32'h0);
    finish_req("rd20_after_abort");
    check("abort_no_write", N'(bus.rdata !== 32'hAAAA5555), N'(1));
    check("abort_old_value", bus.rdata, 32'h11111111);

    // Random mix over a small word set, with aliasing and misalignment.
    for (int n = 0; n < 120; n++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom();
      end else begin
        a = N'($urandom_range(0, 15) * 4);
        a = a + N'($urandom_range(0, 3) * 4 * DEPTH);
        if ($urandom_range(0, 4) == 0) a = a + N'($urandom_range(1, 3));
      end
      start_req(w, a, $urandom());
      finish_req("rand");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
